alu_md: RTL and testbench

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Adds a registered result, more basic ops, and MIPS-style HI/LO multiply/divide computed iteratively, one bit per cycle.
- Sits in the EX stage. The pipeline stalls on in_ready low and consumes results on out_valid.

---
 rtl/alu_md_pkg.sv | 31 +++
 rtl/alu_md_iter.sv | 126 ++++++++++++
 rtl/alu_md.sv | 98 +++++++++
 tb/tb_alu_md.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Shared definitions for the alu_md EX-stage ALU: op codes, FSM states and op width.
package alu_md_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_AND   = 4'd2;
    localparam op_t OP_OR    = 4'd3;
    localparam op_t OP_SRL   = 4'd4;
    localparam op_t OP_SRA   = 4'd5;
    localparam op_t OP_SLL   = 4'd6;
    localparam op_t OP_XOR   = 4'd7;
    localparam op_t OP_SLT   = 4'd8;
    localparam op_t OP_SLTU  = 4'd9;
    localparam op_t OP_MULTU = 4'd10;
    localparam op_t OP_MULT  = 4'd11;
    localparam op_t OP_DIVU  = 4'd12;
    localparam op_t OP_DIV   = 4'd13;
    localparam op_t OP_MTHI  = 4'd14;
    localparam op_t OP_MTLO  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative one-bit-per-cycle multiply/divide engine producing HI/LO.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             idle_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hiAcc_q, loAcc_q, divisor_q, aOrig_q;
    logic             isDiv_q, negLo_q, negHi_q, divZero_q;

    logic             signedOp, aNeg, bNeg, startDiv;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   mulSum, remShift;
    logic [WIDTH-1:0] mulHi, mulLo, divRem, divQuo, remDiff;
    logic             remGe;
    logic [2*WIDTH-1:0] product, productFix;
    logic [WIDTH-1:0] quoFix, remFix;

    assign signedOp = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign startDiv = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign aNeg     = signedOp & a_i[WIDTH-1];
    assign bNeg     = signedOp & b_i[WIDTH-1];
    assign aMag     = aNeg ? -a_i : a_i;
    assign bMag     = bNeg ? -b_i : b_i;

    // hiAcc/loAcc double as product halves for mul and remainder/quotient for div.
    assign mulSum   = {1'b0, hiAcc_q} + (loAcc_q[0] ? {1'b0, divisor_q} : '0);
    assign mulHi    = mulSum[WIDTH:1];
    assign mulLo    = {mulSum[0], loAcc_q[WIDTH-1:1]};

    assign remShift = {hiAcc_q, loAcc_q[WIDTH-1]};
    assign remGe    = remShift >= {1'b0, divisor_q};
    assign remDiff  = remShift[WIDTH-1:0] - divisor_q;
    assign divRem   = remGe ? remDiff : remShift[WIDTH-1:0];
    assign divQuo   = {loAcc_q[WIDTH-2:0], remGe};

    assign product    = {hiAcc_q, loAcc_q};
    assign productFix = negLo_q ? -product : product;
    assign quoFix     = negLo_q ? -loAcc_q : loAcc_q;
    assign remFix     = negHi_q ? -hiAcc_q : hiAcc_q;

    always_comb begin
        hi_o = productFix[2*WIDTH-1:WIDTH];
        lo_o = productFix[WIDTH-1:0];
        if (isDiv_q) begin
            if (divZero_q) begin
                hi_o = aOrig_q;
                lo_o = '1;
            end else begin
                hi_o = remFix;
                lo_o = quoFix;
            end
        end
    end

    assign idle_o = (state_q == ST_IDLE);
    assign done_o = (state_q == ST_FIX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            hiAcc_q   <= '0;
            loAcc_q   <= '0;
            divisor_q <= '0;
            aOrig_q   <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        hiAcc_q   <= '0;
                        loAcc_q   <= aMag;
                        divisor_q <= bMag;
                        aOrig_q   <= a_i;
                        isDiv_q   <= startDiv;
                        negLo_q   <= aNeg ^ bNeg;
                        negHi_q   <= startDiv ? aNeg : (aNeg ^ bNeg);
                        divZero_q <= startDiv && (b_i == '0);
                        count_q   <= CW'(WIDTH);
                        state_q   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (isDiv_q) begin
                        hiAcc_q <= divRem;
                        loAcc_q <= divQuo;
                    end else begin
                        hiAcc_q <= mulHi;
                        loAcc_q <= mulLo;
                    end
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with registered result, single-cycle basic ops and
// iterative MIPS-style HI/LO multiply/divide behind a valid/ready handshake.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] result_q, hi_q, lo_q, aluRes, iterHi, iterLo;
    logic             outValid_q, accept, isMulDiv, iterIdle, iterDone;
    logic [SHW-1:0]   shamt;

    assign shamt    = b[SHW-1:0];
    assign isMulDiv = (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
    assign accept   = in_valid & in_ready;

    always_comb begin
        aluRes = '0;
        case (op)
            OP_ADD:  aluRes = a + b;
            OP_SUB:  aluRes = a - b;
            OP_AND:  aluRes = a & b;
            OP_OR:   aluRes = a | b;
            OP_SRL:  aluRes = a >> shamt;
            OP_SRA:  aluRes = $unsigned($signed(a) >>> shamt);
            OP_SLL:  aluRes = a << shamt;
            OP_XOR:  aluRes = a ^ b;
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
            default: aluRes = '0;
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept & isMulDiv),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .idle_o  (iterIdle),
        .done_o  (iterDone),
        .hi_o    (iterHi),
        .lo_o    (iterLo)
    );

    // The iterator only finishes while in_ready is low, so it never races an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            if (iterDone) begin
                hi_q       <= iterHi;
                lo_q       <= iterLo;
                result_q   <= iterLo;
                outValid_q <= 1'b1;
            end else if (accept && !isMulDiv) begin
                outValid_q <= 1'b1;
                if (op == OP_MTHI) begin
                    hi_q     <= a;
                    result_q <= a;
                end else if (op == OP_MTLO) begin
                    lo_q     <= a;
                    result_q <= a;
                end else begin
                    result_q <= aluRes;
                end
            end
        end
    end

    assign in_ready  = iterIdle;
    assign busy      = !iterIdle;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32 with hand-computed vectors.
module tb_alu_md;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        outValid;
    logic [31:0] result, hi, lo;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int busyCycles;
    int sawPulse;

    alu_md #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (outValid),
        .result    (result),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one op for a single accept edge; returns #1 after that edge.
    task automatic applyStimulus(input logic [3:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        @(negedge clk);
        inValid = 1'b1;
        op      = opIn;
        a       = aIn;
        b       = bIn;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic runBasic(input string tag, input logic [3:0] opIn,
                            input logic [31:0] aIn, input logic [31:0] bIn, input logic [31:0] expRes);
        applyStimulus(opIn, aIn, bIn);
        checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        checkOutput(tag, result, expRes);
    endtask

    // Wait (bounded) for out_valid, counting cycles with in_ready low.
    task automatic waitResult(input string tag, output int cyclesLow);
        int cycles;
        cycles    = 0;
        cyclesLow = 0;
        while (!outValid && cycles < 100) begin
            if (!inReady) cyclesLow++;
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_done"}, {31'd0, outValid}, 32'd1);
    endtask

    task automatic runMulDiv(input string tag, input logic [3:0] opIn, input logic [31:0] aIn,
                             input logic [31:0] bIn, input logic [31:0] expHi, input logic [31:0] expLo);
        applyStimulus(opIn, aIn, bIn);
        waitResult(tag, busyCycles);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
        checkOutput({tag, "_result"}, result, expLo);
    endtask

    initial begin
        rstN    = 1'b0;
        inValid = 1'b0;
        op      = 4'd0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        rstN = 1'b1;

        runBasic("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        @(posedge clk);
        #1;
        checkOutput("add_pulse_end", {31'd0, outValid}, 32'd0);
        checkOutput("result_hold", result, 32'h8000_0000);

        runBasic("sub", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
        runBasic("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        runBasic("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        runBasic("and", 4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
        runBasic("or", 4'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
        runBasic("xor", 4'd7, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
        runBasic("sra", 4'd5, 32'h8000_0000, 32'h24, 32'hF800_0000);
        runBasic("srl", 4'd4, 32'h8000_0000, 32'h24, 32'h0800_0000);
        runBasic("sll", 4'd6, 32'd1, 32'h21, 32'h0000_0002);
        checkOutput("basic_hi_kept", hi, 32'd0);
        checkOutput("basic_lo_kept", lo, 32'd0);

        runMulDiv("mult", 4'd11, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        checkOutput("mult_busy_cycles", busyCycles, 32'd33);
        @(posedge clk);
        #1;
        checkOutput("mult_pulse_end", {31'd0, outValid}, 32'd0);

        runMulDiv("multu", 4'd10, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
        runMulDiv("div_neg", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runMulDiv("divu_zero", 4'd12, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        runMulDiv("div_minneg1", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        runBasic("mthi", 4'd14, 32'h1234, 32'd0, 32'h1234);
        checkOutput("mthi_hi", hi, 32'h1234);
        applyStimulus(4'd10, 32'd3, 32'd4);
        checkOutput("mul_busy_after_accept", {31'd0, inReady}, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_ready", {31'd0, inReady}, 32'd1);
        sawPulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (outValid) sawPulse++;
        end
        checkOutput("abort_no_valid", sawPulse, 32'd0);

        @(negedge clk);
        inValid = 1'b1;
        op      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            a = 32'd10 * i;
            b = i + 1;
            @(posedge clk);
            #1;
            checkOutput("b2b_valid", {31'd0, outValid}, 32'd1);
            checkOutput("b2b_result", result, 32'd11 * i + 32'd1);
        end
        inValid = 1'b0;

        applyStimulus(4'd12, 32'd100, 32'd7);
        inValid = 1'b1;
        op      = 4'd15;
        a       = 32'h0000_ABCD;
        b       = 32'd0;
        waitResult("stall_divu", busyCycles);
        checkOutput("stall_divu_lo", lo, 32'd14);
        checkOutput("stall_divu_hi", hi, 32'd2);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("stall_mtlo_valid", {31'd0, outValid}, 32'd1);
        checkOutput("stall_mtlo_lo", lo, 32'h0000_ABCD);
        checkOutput("stall_mtlo_result", result, 32'h0000_ABCD);
        checkOutput("stall_hi_kept", hi, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
